// File: rtl/display_bcd_scan.sv
// Multiplexed three-digit seven-segment driver for an 8-bit display register.
// A changed byte is converted to BCD by a 9-cycle double-dabble sequencer and
// the resulting hundreds/tens/units digits are scanned onto a shared segment bus.
// Optional feature macro: DISPLAY_LZB_EN (leading-zero blanking of hundreds/tens).
module display_bcd_scan #(
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic       clock,
   input  logic       n_reset,
   input  logic [7:0] value,
   output logic [6:0] seg,
   output logic [2:0] an,
   output logic       busy
);

   localparam int unsigned VAL_W = 8;
   localparam int unsigned DIG_W = 4;
   localparam int unsigned ACC_W = 3 * DIG_W;
   localparam int unsigned SEG_W = 7;
   localparam int unsigned AN_W  = 3;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b1000000;
   localparam logic [AN_W-1:0]  AN_UNITS  = 3'b110;
   localparam logic [AN_W-1:0]  AN_TENS   = 3'b101;
   localparam logic [AN_W-1:0]  AN_HUND   = 3'b011;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   state_t             state_q,    state_d;
   logic [VAL_W-1:0]   last_val_q, last_val_d;
   logic [VAL_W-1:0]   shift_q,    shift_d;
   logic [ACC_W-1:0]   acc_q,      acc_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic               busy_q,     busy_d;
   logic [DIG_W-1:0]   hund_q,     hund_d;
   logic [DIG_W-1:0]   tens_q,     tens_d;
   logic [DIG_W-1:0]   units_q,    units_d;
   logic [PRE_W-1:0]   pre_q,      pre_d;
   logic [IDX_W-1:0]   idx_q,      idx_d;
   logic [AN_W-1:0]    an_q,       an_d;
   logic [SEG_W-1:0]   seg_q,      seg_d;

   logic [ACC_W-1:0]   acc_adj;
   logic [DIG_W-1:0]   sel_digit;
   logic               sel_blank;

   // Double-dabble correction: a nibble >= 5 would overflow past 9 after the shift.
   function automatic logic [DIG_W-1:0] add3(input logic [DIG_W-1:0] nib);
      return (nib >= DIG_W'(5)) ? nib + DIG_W'(3) : nib;
   endfunction

   // Active-low gfedcba pattern for one decimal digit; non-decimal codes blank.
   function automatic logic [SEG_W-1:0] seg_decode(input logic [DIG_W-1:0] d);
      logic [SEG_W-1:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Change detection and the binary-to-BCD conversion sequencer.
   always_comb begin
      state_d    = state_q;
      last_val_d = last_val_q;
      shift_d    = shift_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      hund_d     = hund_q;
      tens_d     = tens_q;
      units_d    = units_q;
      acc_adj    = {add3(acc_q[11:8]), add3(acc_q[7:4]), add3(acc_q[3:0])};

      case (state_q)
         IDLE: begin
            if (value != last_val_q) begin
               last_val_d = value;
               shift_d    = value;
               acc_d      = '0;
               cnt_d      = '0;
               busy_d     = 1'b1;
               state_d    = CONV;
            end
         end
         CONV: begin
            if (cnt_q == CNT_W'(VAL_W)) begin
               hund_d  = acc_q[11:8];
               tens_d  = acc_q[7:4];
               units_d = acc_q[3:0];
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               acc_d   = {acc_adj[ACC_W-2:0], shift_q[VAL_W-1]};
               shift_d = {shift_q[VAL_W-2:0], 1'b0};
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Free-running scan prescaler and digit index, independent of conversion.
   always_comb begin
      pre_d = pre_q + PRE_W'(1);
      idx_d = idx_q;
      if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
         pre_d = '0;
         idx_d = (idx_q == IDX_W'(2)) ? '0 : idx_q + IDX_W'(1);
      end
   end

   // Digit select, leading-zero blanking and segment decode for the active slot.
   always_comb begin
      an_d      = AN_UNITS;
      sel_digit = units_q;
      sel_blank = 1'b0;
      case (idx_q)
         2'd1: begin
            an_d      = AN_TENS;
            sel_digit = tens_q;
`ifdef DISPLAY_LZB_EN
            sel_blank = (hund_q == '0) && (tens_q == '0);
`else
            sel_blank = 1'b0;
`endif
         end
         2'd2: begin
            an_d      = AN_HUND;
            sel_digit = hund_q;
`ifdef DISPLAY_LZB_EN
            sel_blank = (hund_q == '0);
`else
            sel_blank = 1'b0;
`endif
         end
         default: begin
            an_d      = AN_UNITS;
            sel_digit = units_q;
            sel_blank = 1'b0;
         end
      endcase
      seg_d = sel_blank ? SEG_BLANK : seg_decode(sel_digit);
   end

   // All state and registered outputs; reset aborts any conversion in flight.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_q    <= IDLE;
         last_val_q <= '0;
         shift_q    <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         hund_q     <= '0;
         tens_q     <= '0;
         units_q    <= '0;
         pre_q      <= '0;
         idx_q      <= '0;
         an_q       <= AN_UNITS;
         seg_q      <= SEG_ZERO;
      end else begin
         state_q    <= state_d;
         last_val_q <= last_val_d;
         shift_q    <= shift_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         hund_q     <= hund_d;
         tens_q     <= tens_d;
         units_q    <= units_d;
         pre_q      <= pre_d;
         idx_q      <= idx_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign seg  = seg_q;
   assign an   = an_q;
   assign busy = busy_q;

endmodule
